// File: rtl/div_int_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Step counter must hold 0..WIDTH-1 with headroom for the terminal compare.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_int_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_int_step
    import div_int_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Held remainder is always below the divisor, so its top bit is zero and the
    // extra guard bit here only carries the borrow.
    always_comb begin
        shifted = {rem, dvd_msb};
        trial   = shifted - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted[WIDTH:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_int.sv
// Iterative unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Handshake: start is accepted on a rising edge while not busy (IDLE or DONE);
// done pulses for one cycle, and q/r/div_zero are valid from then until the next done.
module div_int
    import div_int_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_step;

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    div_int_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            if (b == '0) begin
                q        <= '1;
                r        <= a;
                div_zero <= 1'b1;
            end else begin
                rem_q <= '0;
                dvd_q <= a;
                dsr_q <= b;
                cnt_q <= '0;
            end
        end else if (state == RUN) begin
            // The dividend register doubles as the quotient shift register.
            rem_q <= rem_next;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
                q        <= {dvd_q[WIDTH-2:0], q_bit};
                r        <= rem_next[WIDTH-1:0];
                div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_int.sv
// Directed bench for div_int: vector table, back-to-back/ignored-start and reset-abort sequences.
module tb_div_int;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;

    div_int #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    // scoreboard: {div_zero, q, r}
    logic [2*W:0] exp_q[$];

    int n_vec;
    int n_bad;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        exp_q.push_back({edz, eq, er});
    endtask

    // Called at a negedge in cycle 0; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int exp_lat, input bit junk);
        logic [2*W:0] e;
        logic [W-1:0] q0, r0;
        logic         busy_ok, held_ok;
        int           lat;
        e = exp_q.pop_front();
        q0 = q;
        r0 = r;
        start = 1'b1;
        a = ta;
        b = tb_v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        while (!done && lat <= 100) begin
            if (busy !== (tb_v != '0)) busy_ok = 1'b0;
            if (q !== q0 || r !== r0) held_ok = 1'b0;
            if (junk && lat >= 5 && lat <= 20) begin
                start = 1'b1;
                a = 9;
                b = 2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (lat > 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: no done for %0h/%0h after 100 cycles", ta, tb_v);
        end else begin
            check("latency", 64'(lat), 64'(exp_lat));
            check("busy_in_run", 64'(busy_ok), 64'd1);
            check("held_in_run", 64'(held_ok), 64'd1);
            check("busy_at_done", 64'(busy), 64'd0);
            check("q", 64'(q), 64'(e[2*W-1:W]));
            check("r", 64'(r), 64'(e[W-1:0]));
            check("div_zero", 64'(div_zero), 64'(e[2*W]));
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{a: 100,           b: 7,            q: 14,           r: 2,    dz: 0, lat: 33};
        vecs[1] = '{a: 32'hFFFFFFFF,  b: 1,            q: 32'hFFFFFFFF, r: 0,    dz: 0, lat: 33};
        vecs[2] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF, q: 1,            r: 0,    dz: 0, lat: 33};
        vecs[3] = '{a: 5,             b: 9,            q: 0,            r: 5,    dz: 0, lat: 33};
        vecs[4] = '{a: 1234,          b: 0,            q: 32'hFFFFFFFF, r: 1234, dz: 1, lat: 1};
        vecs[5] = '{a: 10,            b: 3,            q: 3,            r: 1,    dz: 0, lat: 33};
        vecs[6] = '{a: 0,             b: 5,            q: 0,            r: 0,    dz: 0, lat: 33};
        vecs[7] = '{a: 32'h80000000,  b: 32'h10000,    q: 32'h8000,     r: 0,    dz: 0, lat: 33};
        vecs[8] = '{a: 0,             b: 0,            q: 32'hFFFFFFFF, r: 0,    dz: 1, lat: 1};
        vecs[9] = '{a: 32'hFFFFFFFE,  b: 32'hFFFFFFFF, q: 0,            r: 32'hFFFFFFFE, dz: 0, lat: 33};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_q", 64'(q), 64'd0);
        check("reset_r", 64'(r), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven vectors, one idle cycle between ops
        for (int i = 0; i < 10; i++) begin
            push_exp(vecs[i].q, vecs[i].r, vecs[i].dz);
            run_op(vecs[i].a, vecs[i].b, vecs[i].lat, 1'b0);
            @(negedge clk);
        end

        // ignored starts during RUN, then back-to-back issue in the done cycle
        push_exp(14, 2, 1'b0);
        run_op(100, 7, 33, 1'b1);
        push_exp(4, 1, 1'b0);
        run_op(9, 2, 33, 1'b0);
        @(negedge clk);

        // divide by zero followed directly by a normal op
        push_exp(32'hFFFFFFFF, 1234, 1'b1);
        run_op(1234, 0, 1, 1'b0);
        push_exp(3, 1, 1'b0);
        run_op(10, 3, 33, 1'b0);
        @(negedge clk);

        // reset mid-operation
        start = 1'b1;
        a = 1000;
        b = 3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q", 64'(q), 64'd0);
        check("abort_r", 64'(r), 64'd0);
        check("abort_dz", 64'(div_zero), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(333, 1, 1'b0);
        run_op(1000, 3, 33, 1'b0);
        @(negedge clk);

        // random operands against the language's own / and %
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom_range(1, 255)) : $urandom;
            if (rb == '0) rb = 1;
            push_exp(ra / rb, ra % rb, 1'b0);
            run_op(ra, rb, 33, (i % 7) == 0);
            if (i % 3 == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div_int.md
Name: div_int

Overview:
- Iterative unsigned integer divider: WIDTH-bit dividend / WIDTH-bit divisor gives quotient and remainder.
- Restoring algorithm, one quotient bit per clock.
- Inverse operation to the combinational integer multiplier. Sits beside it in the ALU/coprocessor datapath.
- Trades latency for area, using a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only when not busy.
- a  input  WIDTH  dividend (unsigned), sampled with an accepted start.
- b  input  WIDTH  divisor (unsigned), sampled with an accepted start.
- busy  output  1  division in progress; start is ignored while high.
- done  output  1  one-cycle pulse; q, r and div_zero are valid from this cycle.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- div_zero  output  1  the last completed division had b == 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n = 0, all state clears immediately: state IDLE, busy = 0, done = 0, q = 0, r = 0, div_zero = 0, internal registers 0.
- Reset mid-operation: the operation is aborted with no done pulse. The next start after reset release is accepted normally.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
  - DONE: done = 1 for exactly one cycle, busy = 0.
- Acceptance: start is accepted on a rising edge where the state is IDLE or DONE. Back-to-back issue is allowed, so start in the done cycle is accepted.
- start while in RUN is ignored. It is neither queued nor an error.
- Cycle numbering below: cycle 0 is the cycle in which start is high and accepted.
- Accept, b != 0:
  - Latch the dividend into the quotient-shift register and the divisor into a register.
  - Clear the partial remainder (WIDTH+1 bits) and set step counter = 0.
  - Go to RUN. busy is high in cycles 1..WIDTH.
- RUN step, on each edge:
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted - {0, divisor}, computed in WIDTH+1 bits.
  - If trial is non-negative (MSB = 0): rem = trial and the new quotient LSB = 1. Otherwise rem is restored and LSB = 0.
  - Counter increments.
- Completion:
  - The edge ending cycle WIDTH performs the final step.
  - On that same edge, load q and r, set div_zero = 0 and go to DONE. done = 1 in cycle WIDTH+1.
  - Latency: done rises exactly WIDTH+1 cycles after acceptance (33 for WIDTH = 32).
- Accept with b == 0:
  - No iteration. On the accept edge load q = all ones, r = a, div_zero = 1 and go to DONE.
  - done = 1 in cycle 1; busy is never asserted.
- Output holding: q, r and div_zero hold their values after done until the next completion. They are not updated during RUN.
- Width rules: q = floor(a/b) and r = a mod b, both exact for all a and b with b != 0. No overflow is possible. The remainder register is WIDTH+1 bits internally; r outputs the low WIDTH bits.
- Counter width: clog2(WIDTH)+1 bits. The terminal step is counter == WIDTH-1.
- Inputs a and b may change freely after the accept edge.

Decomposition:
- Shared package div_int_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter-width function
- Sub-module div_int_step: purely combinational single restoring step.
  - Inputs: rem (WIDTH+1), dividend MSB, divisor.
  - Outputs: next rem and quotient bit.
  - Instantiated once and reused every cycle.

Test Plan:
- a = 100, b = 7, start for 1 cycle -> busy high cycles 1..32; done = 1 in cycle 33 only; q = 14, r = 2, div_zero = 0.
- a = 0xFFFFFFFF, b = 1 -> q = 0xFFFFFFFF, r = 0. Then a = 0xFFFFFFFF, b = 0xFFFFFFFF -> q = 1, r = 0. Then a = 5, b = 9 -> q = 0, r = 5.
- a = 1234, b = 0 -> done in cycle 1, busy never high, q = 0xFFFFFFFF, r = 1234, div_zero = 1. Next op 10/3 -> q = 3, r = 1, div_zero = 0.
- Issue 100/7, then hold start with a = 9, b = 2 during cycles 5..20 (ignored); q = 14, r = 2 in cycle 33. Start 9/2 in the done cycle -> done in cycle 66 with q = 4, r = 1.
- Start 1000/3, drop rst_n in cycle 10 for 2 cycles -> busy, done, q, r and div_zero go to 0 immediately, no done pulse. After release, 1000/3 -> q = 333, r = 1 at latency 33.
- Random a and b (b != 0) for 10k ops, compare against a*b-style reference: q*b + r == a and r < b, latency always 33.
